// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing for the 5-stage core (IF, ID, EXE, MEM, WB).
// Produces per-stage enables and valids, load-use stalls, redirect flushes and
// EXE-stage ALU operand forwarding selects.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush/bubble counters.
//
// State is the per-stage valid vector only:
//   valid bit | meaning
//   0         | IF holds a live instruction
//   1         | ID holds a live instruction
//   2         | EXE holds a live instruction
//   3         | MEM holds a live instruction
//   4         | WB holds a live instruction
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W     = 5,
   parameter int REDIRECT_STAGE = 3,
   parameter int CNT_W          = 32
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  enable,
   input  logic                  ext_stall,
   input  logic                  redirect,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] exe_rs,
   input  logic [REG_ADDR_W-1:0] exe_rt,
   input  logic                  exe_mem_read,
   input  logic [REG_ADDR_W-1:0] exe_waddr,
   input  logic [REG_ADDR_W-1:0] mem_waddr,
   input  logic [REG_ADDR_W-1:0] wb_waddr,
   input  logic                  mem_reg_write,
   input  logic                  wb_reg_write,
   output logic                  pc_en,
   output logic [4:0]            stage_en,
   output logic [4:0]            stage_valid,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count,
   output logic [CNT_W-1:0]      bubble_count
`endif
);

   logic [4:0] valid_q;
   logic [4:0] valid_d;
   logic       adv;
   logic       redir;
   logic       luh;

   assign adv   = enable & ~ext_stall;
   assign redir = valid_q[REDIRECT_STAGE] & redirect;
   assign luh   = valid_q[2] & exe_mem_read & (exe_waddr != '0) & valid_q[1] &
                  ((id_uses_rs & (id_rs == exe_waddr)) |
                   (id_uses_rt & (id_rt == exe_waddr)));

   assign stage_valid = valid_q;

   // Valid register: cleared asynchronously, otherwise loads the next-state vector.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) valid_q <= '0;
      else      valid_q <= valid_d;
   end

   // Next-state valids: redirect squashes up to the resolve stage, load-use inserts an EXE bubble.
   always_comb begin
      valid_d = valid_q;
      if (adv) begin
         if (redir) begin
            valid_d[0] = 1'b1;
            for (int i = 1; i < 5; i++)
               valid_d[i] = (i <= REDIRECT_STAGE) ? 1'b0 : valid_q[i-1];
         end else if (luh) begin
            valid_d = {valid_q[3], valid_q[2], 1'b0, valid_q[1:0]};
         end else begin
            valid_d = {valid_q[3:0], 1'b1};
         end
      end
   end

   // Enables and forwarding selects; enables forced low while reset is asserted.
   always_comb begin
      pc_en    = 1'b0;
      stage_en = 5'b00000;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
      if (!arst && adv) begin
         if (redir || !luh) begin
            pc_en    = 1'b1;
            stage_en = 5'b11111;
         end else begin
            stage_en = 5'b11100;
         end
      end
      if (valid_q[2]) begin
         if (valid_q[3] && mem_reg_write && (mem_waddr != '0) && (mem_waddr == exe_rs))
            fwd_a = 2'b01;
         else if (valid_q[4] && wb_reg_write && (wb_waddr != '0) && (wb_waddr == exe_rs))
            fwd_a = 2'b10;
         if (valid_q[3] && mem_reg_write && (mem_waddr != '0) && (mem_waddr == exe_rt))
            fwd_b = 2'b01;
         else if (valid_q[4] && wb_reg_write && (wb_waddr != '0) && (wb_waddr == exe_rt))
            fwd_b = 2'b10;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturating performance counters; an accepted redirect hides any coincident load-use.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (enable && ext_stall && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_ONE;
         if (adv && redir && !(&flush_count))
            flush_count <= flush_count + CNT_ONE;
         if (adv && !redir && luh && !(&bubble_count))
            bubble_count <= bubble_count + CNT_ONE;
      end
   end
`endif

endmodule
